// File: rtl/register_file_if.sv
// Dispatcher/ROB-facing bus of the architectural register file.
// The register file takes the slave modport; the dispatcher/ROB side takes master.
interface register_file_if;
    logic [4:0]  rs1_from_dispatcher;
    logic [4:0]  rs2_from_dispatcher;
    logic [31:0] V1_to_dispatcher;
    logic [31:0] V2_to_dispatcher;
    logic [4:0]  Q1_to_dispatcher;
    logic [4:0]  Q2_to_dispatcher;
    logic        enable_from_dispatcher;
    logic [4:0]  rd_from_dispatcher;
    logic [4:0]  rob_id_from_dispatcher;
    logic        commit_flag;
    logic [4:0]  rd_from_rob;
    logic [31:0] V_from_rob;
    logic [4:0]  Q_from_rob;
    logic        rollback_flag;
    logic [31:0] dbg_commit_cnt;

    modport master (
        output rs1_from_dispatcher, rs2_from_dispatcher,
        output enable_from_dispatcher, rd_from_dispatcher, rob_id_from_dispatcher,
        output commit_flag, rd_from_rob, V_from_rob, Q_from_rob, rollback_flag,
        input  V1_to_dispatcher, V2_to_dispatcher, Q1_to_dispatcher, Q2_to_dispatcher,
        input  dbg_commit_cnt
    );

    modport slave (
        input  rs1_from_dispatcher, rs2_from_dispatcher,
        input  enable_from_dispatcher, rd_from_dispatcher, rob_id_from_dispatcher,
        input  commit_flag, rd_from_rob, V_from_rob, Q_from_rob, rollback_flag,
        output V1_to_dispatcher, V2_to_dispatcher, Q1_to_dispatcher, Q2_to_dispatcher,
        output dbg_commit_cnt
    );
endinterface

// File: rtl/register_file.sv
// 32-entry architectural register file with ROB rename tags, commit bypass
// on reads, mispredict rollback and a commit counter.
module register_file (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           rdy_in,
    register_file_if.slave bus
);
    logic [31:0] r_value [32];
    logic [4:0]  r_tag   [32];
    logic [31:0] r_commit_cnt;

    logic        w_commit_wr;
    logic        w_tag_clr;
    logic        w_rename;
    logic [31:0] w_v1;
    logic [31:0] w_v2;
    logic [4:0]  w_q1;
    logic [4:0]  w_q2;

    // rd_from_rob != 0 here also keeps x0 out of the read bypass below.
    assign w_commit_wr = bus.commit_flag && (bus.rd_from_rob != '0);
    assign w_tag_clr   = w_commit_wr && (r_tag[bus.rd_from_rob] == bus.Q_from_rob);
    assign w_rename    = bus.enable_from_dispatcher && !bus.rollback_flag &&
                         (bus.rd_from_dispatcher != '0);

    always_comb begin
        w_v1 = r_value[bus.rs1_from_dispatcher];
        w_q1 = r_tag[bus.rs1_from_dispatcher];
        w_v2 = r_value[bus.rs2_from_dispatcher];
        w_q2 = r_tag[bus.rs2_from_dispatcher];
        if (w_commit_wr && (bus.rd_from_rob == bus.rs1_from_dispatcher) &&
            (r_tag[bus.rs1_from_dispatcher] == bus.Q_from_rob)) begin
            w_v1 = bus.V_from_rob;
            w_q1 = '0;
        end
        if (w_commit_wr && (bus.rd_from_rob == bus.rs2_from_dispatcher) &&
            (r_tag[bus.rs2_from_dispatcher] == bus.Q_from_rob)) begin
            w_v2 = bus.V_from_rob;
            w_q2 = '0;
        end
    end

    assign bus.V1_to_dispatcher = w_v1;
    assign bus.V2_to_dispatcher = w_v2;
    assign bus.Q1_to_dispatcher = w_q1;
    assign bus.Q2_to_dispatcher = w_q2;
    assign bus.dbg_commit_cnt   = r_commit_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_value      <= '{default: '0};
            r_tag        <= '{default: '0};
            r_commit_cnt <= '0;
        end else if (rdy_in) begin
            if (bus.commit_flag) begin
                r_commit_cnt <= r_commit_cnt + 32'd1;
            end
            if (w_commit_wr) begin
                r_value[bus.rd_from_rob] <= bus.V_from_rob;
            end
            if (bus.rollback_flag) begin
                r_tag <= '{default: '0};
            end else begin
                // Rename is written last so it wins over a same-rd tag clear.
                if (w_tag_clr) begin
                    r_tag[bus.rd_from_rob] <= '0;
                end
                if (w_rename) begin
                    r_tag[bus.rd_from_dispatcher] <= bus.rob_id_from_dispatcher;
                end
            end
        end
    end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have the port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have the port rdy_in, input, 1 bit: global ready; when low, all state SHALL hold.
REQ-004 The block SHALL have the ports rs1_from_dispatcher and rs2_from_dispatcher, input, REG_TYPE (5 bits): source register indices.
REQ-005 The block SHALL have the ports V1_to_dispatcher and V2_to_dispatcher, output, DATA_TYPE (32 bits): architectural value of rs1 and rs2.
REQ-006 The block SHALL have the ports Q1_to_dispatcher and Q2_to_dispatcher, output, ROB_TYPE (5 bits): pending ROB tag of rs1 and rs2, where ROB_RESET (0) means the value is valid.
REQ-007 The block SHALL have the ports enable_from_dispatcher (input, 1 bit), rd_from_dispatcher (input, 5 bits) and rob_id_from_dispatcher (input, 5 bits): rename request, rob_id nonzero.
REQ-008 The block SHALL have the ports commit_flag (input, 1 bit), rd_from_rob (input, 5 bits), V_from_rob (input, 32 bits) and Q_from_rob (input, 5 bits): registered commit from the ROB.
REQ-009 The block SHALL have the port rollback_flag, input, 1 bit: mispredict flush, asserted in the same cycle as the committing branch.
REQ-010 The block SHALL have the port dbg_commit_cnt, output, 32 bits: count of accepted commits.

Function
REQ-011 The block SHALL hold 32 entries, each a 32-bit value plus a 5-bit tag.
REQ-012 x0 SHALL read V=0 and Q=0 at all times, and writes or renames to rd=0 SHALL be ignored.
REQ-013 Reads SHALL be combinational: Vn=value[rsn] and Qn=tag[rsn], with the commit bypass of REQ-014 applied.
REQ-014 Commit bypass: if commit_flag, rd_from_rob==rsn!=0 and tag[rsn]==Q_from_rob, then Vn=V_from_rob and Qn=0 in the same cycle.
REQ-015 Reads SHALL NOT bypass a same-cycle rename; the dispatched instruction sees pre-rename state, so rs==rd reads the old mapping.
REQ-016 On a clock edge with rdy_in high, commit_flag high and rd_from_rob!=0, the block SHALL write value[rd] with V_from_rob unconditionally.
REQ-017 Under the same conditions, tag[rd] SHALL be cleared to 0 only if tag[rd]==Q_from_rob; a younger tag is kept.
REQ-018 On a clock edge with rdy_in high, enable_from_dispatcher high, rollback_flag low and rd!=0, the block SHALL set tag[rd] to rob_id_from_dispatcher.
REQ-019 A simultaneous commit and rename to the same rd SHALL write the value and leave the tag equal to the new rob_id; rename wins over the tag clear.
REQ-020 On rollback_flag with rdy_in high, the block SHALL clear all 32 tags to 0, drop any same-cycle rename, and still apply the same-cycle commit value write.
REQ-021 dbg_commit_cnt SHALL increment by 1 per edge with rdy_in and commit_flag high (including rd=0) and SHALL wrap modulo 2^32.
REQ-022 When rdy_in is low, the block SHALL ignore commit, rename and rollback, while combinational reads stay live.

Reset
REQ-023 While rst_n_in is low, the block SHALL clear all values and tags to 0 and dbg_commit_cnt to 0, asynchronously and independent of clk_in and rdy_in.
REQ-024 Consequently all read outputs SHALL be 0 during and after reset, and a commit or rename in flight at reset assertion SHALL be lost.
REQ-025 State updates SHALL resume on the first rising edge after rst_n_in returns high.

Verification
REQ-026 The bench SHALL cover rename then commit: rename x5->tag 3; next cycle read rs1=5 -> Q1=3; commit rd=5 V=0xDEAD Q=3 with rs1=5 -> same cycle V1=0xDEAD, Q1=0; after the edge tag[5]=0, value=0xDEAD.
REQ-027 The bench SHALL cover a stale commit: rename x7->2, then rename x7->9, then commit rd=7 V=0x11 Q=2 -> value[7]=0x11, tag[7] stays 9, and no bypass when reading x7 (Q=9).
REQ-028 The bench SHALL cover a same-cycle commit and rename: commit rd=4 Q=tag[4] V=0x22 together with rename x4->6 -> after the edge value[4]=0x22, tag[4]=6.
REQ-029 The bench SHALL cover rollback: tags set on x1..x31, then rollback_flag with commit rd=1 V=0x40 and rename x2->8 -> all tags 0, value[1]=0x40, tag[2]=0.
REQ-030 The bench SHALL cover x0 and rdy_in: rename x0->5 and commit rd=0 V=0xFF -> x0 reads 0/0 and dbg_commit_cnt increments; with rdy_in=0 a commit -> no state change.
REQ-031 The bench SHALL cover asynchronous reset: assert rst_n_in low mid-cycle with state populated -> all outputs 0 immediately, before the next clk_in edge.
